restoring_divider_32: RTL and testbench
=======================================

# restoring_divider_32

Sequential 32-bit unsigned restoring divider. It sits directly downstream of `full_subtractor_32` and uses it as its trial-subtract datapath, producing one quotient bit per clock. It accepts a dividend/divisor pair on a `start` pulse and returns quotient and remainder with a `done` pulse. It is the multi-cycle divide unit of the arithmetic block set.

## Interface
- `WIDTH`, 32, operand/result width. The datapath is built for 32 only; other values are unsupported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  **synchronous, active-low reset**, sampled on the rising edge of `clk`.
- `start`  in  1  request; accepted only in IDLE.
- `dividend`  in  32  unsigned numerator, sampled when `start` is accepted.
- `divisor`  in  32  unsigned denominator, sampled when `start` is accepted.
- `busy`  out  1  high in CALC and DONE.
- `done`  out  1  one-cycle pulse; results valid from this cycle on.
- `quotient`  out  32  result, held until the next accepted `start`.
- `remainder`  out  32  result, held until the next accepted `start`.
- `div_by_zero`  out  1  set with `done` when divisor was 0; held with the results.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE → CALC on `start` with a nonzero divisor.
  - IDLE → DONE on `start` with a zero divisor.
  - CALC → DONE when the 32nd iteration completes.
  - DONE → IDLE unconditionally.
- Accepting `start` (IDLE):
  - Q ← dividend, R ← 0, D ← divisor, counter ← 0.
  - Clear `div_by_zero` and the previous results.
- CALC iteration (one per cycle):
  - Form the shifted value S = {R[30:0], Q[31]} and capture the overflow bit c = R[31].
  - Feed S and D to `full_subtractor_32` with `bin` = 0.
  - Subtraction succeeds if c = 1 or `bout` = 0. The 33-bit shifted value is then ≥ D, which is required when D[31] = 1.
  - On success: R ← d, and shift 1 into Q.
  - On failure: R ← S, and shift 0 into Q.
  - Increment the counter. The iteration with counter = 31 is the last.
- Results:
  - On entering DONE, `quotient` ← Q and `remainder` ← R.
  - In the divide-by-zero path, `quotient` = 0xFFFF_FFFF, `remainder` = dividend, and `div_by_zero` = 1.
- `start` is ignored while `busy` is high, including in DONE. Operand inputs are don't-care except in the acceptance cycle.

## Timing
- Reset value of every output: `busy` = 0, `done` = 0, `quotient` = 0, `remainder` = 0, `div_by_zero` = 0. The FSM is in IDLE and the counter is 0.
- Normal latency:
  - `start` is sampled at edge 0.
  - Edges 1–32 perform the iterations.
  - `done` is high for the cycle after edge 32.
  - `busy` = 1 from after edge 0 through the DONE cycle.
  - Total is 33 cycles from `start` to `done`; the next `start` is accepted one cycle after `done`.
- Divide-by-zero latency: `done` is high for the cycle after edge 0, i.e. 1 cycle.
- Results and `div_by_zero` change only on entry to DONE or on `start` acceptance. They are stable otherwise.
- Reset asserted mid-CALC: the next edge forces all reset values and discards the partial result. No `done` is issued.
- `start` and `rst_n` = 0 in the same cycle: reset wins and `start` is lost.

## Structure
- Shared package `div_pkg`:
  - `div_state_t` enum (IDLE, CALC, DONE).
  - `DIV_WIDTH` = 32.
  - `DIV_ITER_LAST` = 31.
  - `DIV_ZERO_QUOT` = 32'hFFFF_FFFF.
- Single sub-module instance: `full_subtractor_32` (x = S, y = D, bin = 0 → d, bout). There is no behavioural `-` operator in the datapath.
- Registers: state, 5-bit counter, Q, R, D, result and flag registers.

## Test plan
- 100 / 7 → `quotient` = 14, `remainder` = 2, `div_by_zero` = 0, `done` exactly 33 cycles after `start`, single-cycle pulse.
- 0xFFFF_FFFF / 0x8000_0000 → `quotient` = 1, `remainder` = 0x7FFF_FFFF (exercises the c = 1 path). Also 0xFFFF_FFFF / 1 → `quotient` = 0xFFFF_FFFF, `remainder` = 0.
- 5 / 0 → `done` 1 cycle after `start`, `quotient` = 0xFFFF_FFFF, `remainder` = 5, `div_by_zero` = 1. A following 9 / 3 clears the flag and gives `quotient` = 3, `remainder` = 0.
- `start` with 50 / 5 at cycles 0, 10 and 32 (the last during DONE) → only the first is accepted; single `done` with `quotient` = 10, `remainder` = 0.
- `rst_n` low at cycle 15 of a divide → the next cycle shows all outputs 0 and FSM IDLE, with no `done`. A subsequent 7 / 2 → `quotient` = 3, `remainder` = 1.
- 1000 random operand pairs, including zero and all-ones operands → `quotient` and `remainder` match the / and % model, and the 33-cycle latency holds for every nonzero divisor.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH     = 32;
  localparam logic [4:0]  DIV_ITER_LAST = 5'd31;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/full_subtractor_32.sv
// 32-bit ripple-borrow subtractor: d = x - y - bin, bout = borrow out of the MSB.
module full_subtractor_32
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] x,
  input  logic [DIV_WIDTH-1:0] y,
  input  logic                 bin,
  output logic [DIV_WIDTH-1:0] d,
  output logic                 bout
);

  // Bit-serial borrow chain built from one-bit full subtractors.
  always_comb begin
    logic brw;
    brw = bin;
    d   = '0;
    for (int i = 0; i < DIV_WIDTH; i++) begin
      d[i] = x[i] ^ y[i] ^ brw;
      brw  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw);
    end
    bout = brw;
  end

endmodule

// File: rtl/restoring_divider_32.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per clock.
module restoring_divider_32
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] diff;
  logic             ovf;
  logic             borrow;
  logic             success;
  logic [WIDTH-1:0] iter_q;
  logic [WIDTH-1:0] iter_r;

  // Shifted partial remainder; ovf is the 33rd bit, which guarantees S >= D when set.
  assign shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign ovf     = r_q[WIDTH-1];
  assign success = ovf | ~borrow;
  assign iter_r  = success ? diff : shifted;
  assign iter_q  = {q_q[WIDTH-2:0], success};

  full_subtractor_32 u_sub (
    .x    (shifted),
    .y    (dvs_q),
    .bin  (1'b0),
    .d    (diff),
    .bout (borrow)
  );

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_d    = dividend;
          r_d    = '0;
          dvs_d  = divisor;
          cnt_d  = '0;
          quot_d = '0;
          rem_d  = '0;
          dbz_d  = 1'b0;
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = DIV_ZERO_QUOT;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        q_d   = iter_q;
        r_d   = iter_r;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == DIV_ITER_LAST) begin
          state_d = DONE;
          quot_d  = iter_q;
          rem_d   = iter_r;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_32.sv
// Scoreboard bench for restoring_divider_32.
module tb_restoring_divider_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  restoring_divider_32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: plain divide; 1: extra starts at cycle 10 and during DONE; 2: reset at cycle 15.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int mode);
    exp_t e;
    exp_t got_e;
    int   cyc;
    e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dbz = (b == 0);
    e.lat = (b == 0) ? 1 : 33;
    sb.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    cyc      = 1;
    while (!done && cyc < 40) begin
      if (cyc == 5) begin
        check("busy_calc", busy, 1);
        check("quot_cleared", quotient, 0);
        check("rem_cleared", remainder, 0);
      end
      if (mode == 1 && cyc == 10) begin
        start    = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd3;
      end
      if (mode == 2 && cyc == 15) rst_n = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (mode == 2 && cyc == 16) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        void'(sb.pop_front());
        repeat (40) begin
          @(negedge clk);
          check("rst_no_done", done, 0);
        end
        return;
      end
    end
    got_e = sb.pop_front();
    check("done_seen", done, 1);
    check("latency", cyc, got_e.lat);
    check("quotient", quotient, got_e.q);
    check("remainder", remainder, got_e.r);
    check("div_by_zero", div_by_zero, got_e.dbz);
    if (mode == 1) begin
      start    = 1'b1;
      dividend = 32'd91;
      divisor  = 32'd4;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("quot_held", quotient, got_e.q);
    check("rem_held", remainder, got_e.r);
    if (mode == 1) begin
      @(negedge clk);
      check("late_start_ignored", busy, 0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quot", quotient, 0);
    check("reset_rem", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    // Start coincident with reset is lost.
    start    = 1'b1;
    dividend = 32'd10;
    divisor  = 32'd2;
    @(negedge clk);
    start = 1'b0;
    check("start_during_reset", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_div(32'd100, 32'd7, 0);
    run_div(32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_div(32'hFFFF_FFFF, 32'd1, 0);
    run_div(32'd5, 32'd0, 0);
    run_div(32'd9, 32'd3, 0);
    run_div(32'd50, 32'd5, 1);
    run_div(32'd1000, 32'd3, 2);
    run_div(32'd7, 32'd2, 0);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'hFFFF_FFFF;
        2: b = 32'hFFFF_FFFF;
        3: a = 32'd0;
        4: b = 32'($urandom_range(1, 15));
        5: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      run_div(a, b, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
